// File: rtl/simple_bus_decoder_pkg.sv
// Shared types and constants for the single-master bus decoder and its
// address matcher.
package simple_bus_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    localparam int          ERR_CNT_W      = 8;
    localparam logic [31:0] ERR_RD_DEFAULT = 32'hDEAD_BEEF;

    // Wide enough for the largest supported fan-out of 8 slaves.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        RSEL_IDLE,
        RSEL_SLV,
        RSEL_ERR
    } rsel_kind_e;

    typedef struct packed {
        rsel_kind_e        kind;
        logic [IDX_W-1:0]  idx;
    } rsel_t;

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/simple_bus_decoder_addr_match.sv
// Combinational base/mask window matcher; on overlapping windows the lowest
// slave index wins.
module simple_addr_match
    import simple_bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [31:0]        addr_i,
    input  logic [N-1:0][31:0] base_i,
    input  logic [N-1:0][31:0] mask_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   hit_idx_o
);

    // Scan from the top down so the last assignment is the lowest index.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((addr_i & mask_i[i]) == base_i[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/simple_bus_decoder.sv
// One-master to s_w-slave bus decoder with one-cycle read steering and
// fault capture (first faulting address, saturating count).
module simple_bus_decoder
    import simple_bus_pkg::*;
#(
    parameter int                    s_w      = 4,
    parameter logic [s_w-1:0][31:0]  slv_base = {32'h3000_0000, 32'h2000_0000,
                                                 32'h1000_0000, 32'h0000_0000},
    parameter logic [s_w-1:0][31:0]  slv_mask = {s_w{32'hF000_0000}},
    parameter logic [31:0]           err_rd   = ERR_RD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_m,
    input  logic [31:0]           addr_m,
    input  logic [31:0]           wd_m,
    input  logic                  we_m,
    input  logic [1:0]            size_m,
    output logic [31:0]           rd_m,
    output logic                  err_m,
    output logic [s_w-1:0]        req_s,
    output logic [s_w-1:0]        we_s,
    output logic [31:0]           addr_s,
    output logic [31:0]           wd_s,
    output logic [1:0]            size_s,
    input  logic [s_w-1:0][31:0]  rd_s,
    output logic [31:0]           err_addr,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    input  logic                  err_clr
);

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             fault;
    logic             accept;

    rsel_t                rsel_q, rsel_d;
    logic                 err_q, err_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 sticky_q, sticky_d;

    simple_addr_match #(
        .N (s_w)
    ) u_match (
        .addr_i    (addr_m),
        .base_i    (slv_base),
        .mask_i    (slv_mask),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    assign addr_s = addr_m;
    assign wd_s   = wd_m;
    assign size_s = size_m;

    always_comb begin
        fault  = req_m && (!hit || is_misaligned(size_m, addr_m[1:0]));
        accept = req_m && !fault;
        for (int i = 0; i < s_w; i++) begin
            req_s[i] = accept && (hit_idx == i[IDX_W-1:0]);
        end
        we_s = req_s & {s_w{we_m}};
    end

    // Read steering: remember who owes us data next cycle.
    always_comb begin
        rsel_d = '{kind: RSEL_IDLE, idx: '0};
        if (req_m && !we_m) begin
            if (accept) begin
                rsel_d = '{kind: RSEL_SLV, idx: hit_idx};
            end else begin
                rsel_d = '{kind: RSEL_ERR, idx: '0};
            end
        end
    end

    always_comb begin
        rd_m = '0;
        case (rsel_q.kind)
            RSEL_SLV: begin
                for (int i = 0; i < s_w; i++) begin
                    if (rsel_q.idx == i[IDX_W-1:0]) begin
                        rd_m = rd_s[i];
                    end
                end
            end
            RSEL_ERR: rd_m = err_rd;
            default:  rd_m = '0;
        endcase
    end

    // A clear in the same cycle as a fault wipes old state first, so the new
    // fault becomes the first one recorded.
    always_comb begin
        err_d      = fault;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        sticky_d   = sticky_q;
        if (err_clr) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
            sticky_d   = 1'b0;
        end
        if (fault) begin
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + 1'b1;
            end
            if (!sticky_d) begin
                err_addr_d = addr_m;
                sticky_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsel_q     <= '{kind: RSEL_IDLE, idx: '0};
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            sticky_q   <= 1'b0;
        end else begin
            rsel_q     <= rsel_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign err_m    = err_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_simple_bus_decoder.sv
// Directed bench for simple_bus_decoder: routing, read steering, fault
// capture, saturation, clear priority and asynchronous reset.
module tb_simple_bus_decoder;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req_m;
    logic [31:0]      addr_m;
    logic [31:0]      wd_m;
    logic             we_m;
    logic [1:0]       size_m;
    logic [31:0]      rd_m;
    logic             err_m;
    logic [3:0]       req_s;
    logic [3:0]       we_s;
    logic [31:0]      addr_s;
    logic [31:0]      wd_s;
    logic [1:0]       size_s;
    logic [3:0][31:0] rd_s;
    logic [31:0]      err_addr;
    logic [7:0]       err_cnt;
    logic             err_clr;

    int totalChecks = 0;
    int badChecks   = 0;

    simple_bus_decoder dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_m    (req_m),
        .addr_m   (addr_m),
        .wd_m     (wd_m),
        .we_m     (we_m),
        .size_m   (size_m),
        .rd_m     (rd_m),
        .err_m    (err_m),
        .req_s    (req_s),
        .we_s     (we_s),
        .addr_s   (addr_s),
        .wd_s     (wd_s),
        .size_s   (size_s),
        .rd_s     (rd_s),
        .err_addr (err_addr),
        .err_cnt  (err_cnt),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1ns after the rising edge; registered outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wd);
        req_m  = req;
        we_m   = we;
        addr_m = addr;
        size_m = size;
        wd_m   = wd;
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        req_m   = 1'b0;
        we_m    = 1'b0;
        addr_m  = '0;
        wd_m    = '0;
        size_m  = 2'd0;
        err_clr = 1'b0;
        rd_s[0] = 32'h0000_0011;
        rd_s[1] = 32'h0000_0022;
        rd_s[2] = 32'h0000_0044;
        rd_s[3] = 32'h0000_0033;
        #2;
        checkOutput("reset_rd_m", rd_m, 32'h0);
        checkOutput("reset_err_m", {31'b0, err_m}, 32'h0);
        checkOutput("reset_err_addr", err_addr, 32'h0);
        checkOutput("reset_err_cnt", {24'b0, err_cnt}, 32'h0);
        checkOutput("reset_req_s", {28'b0, req_s}, 32'h0);
        rstn = 1'b1;

        tick();
        applyStimulus(1'b1, 1'b1, 32'h1000_0004, 2'd2, 32'hA5A5_A5A5);
        checkOutput("wr_req_s", {28'b0, req_s}, 32'h2);
        checkOutput("wr_we_s", {28'b0, we_s}, 32'h2);
        checkOutput("wr_wd_s", wd_s, 32'hA5A5_A5A5);
        checkOutput("wr_addr_s", addr_s, 32'h1000_0004);
        tick();
        checkOutput("wr_err_m", {31'b0, err_m}, 32'h0);
        checkOutput("wr_rd_m_idle", rd_m, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'd2, 32'h0);
        checkOutput("rd0_req_s", {28'b0, req_s}, 32'h1);
        checkOutput("rd0_we_s", {28'b0, we_s}, 32'h0);
        tick();
        checkOutput("rd0_rd_m", rd_m, 32'h11);
        applyStimulus(1'b1, 1'b0, 32'h3000_0020, 2'd2, 32'h0);
        checkOutput("rd3_req_s", {28'b0, req_s}, 32'h8);
        tick();
        checkOutput("rd3_rd_m", rd_m, 32'h33);
        applyStimulus(1'b1, 1'b0, 32'h2000_0002, 2'd1, 32'h0);
        checkOutput("rdh_req_s", {28'b0, req_s}, 32'h4);
        tick();
        checkOutput("rdh_rd_m", rd_m, 32'h44);
        checkOutput("rdh_err_m", {31'b0, err_m}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        checkOutput("idle_req_s", {28'b0, req_s}, 32'h0);
        tick();
        checkOutput("idle_rd_m", rd_m, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h5000_0000, 2'd2, 32'h0);
        checkOutput("unmap_req_s", {28'b0, req_s}, 32'h0);
        tick();
        checkOutput("unmap_rd_m", rd_m, 32'hDEAD_BEEF);
        checkOutput("unmap_err_m", {31'b0, err_m}, 32'h1);
        checkOutput("unmap_err_addr", err_addr, 32'h5000_0000);
        checkOutput("unmap_err_cnt", {24'b0, err_cnt}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("unmap_err_m_pulse", {31'b0, err_m}, 32'h0);
        checkOutput("clr_err_cnt", {24'b0, err_cnt}, 32'h0);
        checkOutput("clr_err_addr", err_addr, 32'h0);

        applyStimulus(1'b1, 1'b1, 32'h2000_0002, 2'd2, 32'h1234_5678);
        checkOutput("misw_req_s", {28'b0, req_s}, 32'h0);
        checkOutput("misw_we_s", {28'b0, we_s}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h2000_0001, 2'd1, 32'h1234_5678);
        checkOutput("mish_req_s", {28'b0, req_s}, 32'h0);
        tick();
        checkOutput("mis_err_m", {31'b0, err_m}, 32'h1);
        checkOutput("mis_err_cnt", {24'b0, err_cnt}, 32'h2);
        checkOutput("mis_err_addr", err_addr, 32'h2000_0002);
        checkOutput("mis_rd_m", rd_m, 32'h0);

        // Mix of illegal size, odd halfword and unmapped address.
        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       applyStimulus(1'b1, 1'b1, 32'h0000_0000, 2'd3, 32'h0);
                1:       applyStimulus(1'b1, 1'b1, 32'h1000_0003, 2'd1, 32'h0);
                default: applyStimulus(1'b1, 1'b1, 32'h9000_0000, 2'd0, 32'h0);
            endcase
            tick();
        end
        checkOutput("sat_err_cnt", {24'b0, err_cnt}, 32'hFF);
        checkOutput("sat_err_addr", err_addr, 32'h2000_0002);

        err_clr = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h7000_0000, 2'd2, 32'h0);
        tick();
        err_clr = 1'b0;
        checkOutput("clrf_err_cnt", {24'b0, err_cnt}, 32'h1);
        checkOutput("clrf_err_addr", err_addr, 32'h7000_0000);
        checkOutput("clrf_rd_m", rd_m, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 32'h6000_0000, 2'd2, 32'h0);
        tick();
        checkOutput("sticky_err_cnt", {24'b0, err_cnt}, 32'h2);
        checkOutput("sticky_err_addr", err_addr, 32'h7000_0000);

        applyStimulus(1'b1, 1'b0, 32'h1000_0000, 2'd2, 32'h0);
        tick();
        checkOutput("pre_rst_rd_m", rd_m, 32'h22);
        applyStimulus(1'b1, 1'b0, 32'h3000_0000, 2'd2, 32'h0);
        checkOutput("pre_rst_rd_m_hold", rd_m, 32'h22);
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_rd_m", rd_m, 32'h0);
        checkOutput("async_rst_err_m", {31'b0, err_m}, 32'h0);
        checkOutput("async_rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        checkOutput("async_rst_err_addr", err_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        #2;
        rstn = 1'b1;
        tick();
        checkOutput("post_rst_rd_m", rd_m, 32'h0);
        checkOutput("post_rst_err_m", {31'b0, err_m}, 32'h0);
        checkOutput("post_rst_err_cnt", {24'b0, err_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
